seg_led_decoder: RTL and testbench

Receive-side counterpart of the two-digit seven-segment driver (`seg_led_top`). It samples the multiplexed `digit_select`/`seg_led` lines, waits until each digit pattern is stable, and decodes it back to hex. It then reassembles the two-digit value and reports each new frame with a one-cycle strobe. It is used for on-board loopback checking of the display path and as the decode stage of the display bench scoreboard.

---
 rtl/seg_led_decoder_if.sv | 34 +++
 rtl/seg_led_decoder.sv | 150 +++++++++++++++
 tb/tb_seg_led_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_led_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_led_decoder_if: muxed display lines in, decoded frame and strobes out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seg_led_decoder_if;
  logic       digit_select;
  logic [6:0] seg_led;
  logic [7:0] value;
  logic [1:0] blank;
  logic       value_valid;
  logic       pattern_err;

  modport master (
    output digit_select,
    output seg_led,
    input  value,
    input  blank,
    input  value_valid,
    input  pattern_err
  );

  modport slave (
    input  digit_select,
    input  seg_led,
    output value,
    output blank,
    output value_valid,
    output pattern_err
  );
endinterface

`default_nettype wire

// File: rtl/seg_led_decoder.sv
// ---------------------------------------------------------------------------
// seg_led_decoder: debounces muxed seven-segment lines, decodes hex, frames.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_led_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  seg_led_decoder_if.slave  bus
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_SAT    = CW'(STABLE_CYCLES);
  // The change-detect edge and the current edge are samples too, so cnt
  // trails the number of identical samples by two.
  localparam logic [CW-1:0] C_ACCEPT = CW'(STABLE_CYCLES - 2);

  typedef enum logic [0:0] {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    prev;
  logic [CW-1:0] cnt;
  logic          changed;
  logic          commit;
  logic [3:0]    nib;
  logic          pat_ok;
  logic          pat_blank;
  logic [7:0]    digits;
  logic [1:0]    dblank;
  logic [1:0]    seen;
  logic          first;
  logic [7:0]    value_q;
  logic [1:0]    blank_q;
  logic          value_valid_q;
  logic          pattern_err_q;

  assign changed         = (s2 != prev);
  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.value_valid = value_valid_q;
  assign bus.pattern_err = pattern_err_q;

  always_comb begin
    nib       = 4'h0;
    pat_ok    = 1'b1;
    pat_blank = 1'b0;
    case (s2[6:0])
      7'h3F:   nib = 4'h0;
      7'h06:   nib = 4'h1;
      7'h5B:   nib = 4'h2;
      7'h4F:   nib = 4'h3;
      7'h66:   nib = 4'h4;
      7'h6D:   nib = 4'h5;
      7'h7D:   nib = 4'h6;
      7'h07:   nib = 4'h7;
      7'h7F:   nib = 4'h8;
      7'h6F:   nib = 4'h9;
      7'h77:   nib = 4'hA;
      7'h7C:   nib = 4'hB;
      7'h39:   nib = 4'hC;
      7'h5E:   nib = 4'hD;
      7'h79:   nib = 4'hE;
      7'h71:   nib = 4'hF;
      7'h00:   pat_blank = 1'b1;
      default: pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      SETTLE: begin
        if (!changed && (cnt == C_ACCEPT)) begin
          commit    = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (changed) state_nxt = SETTLE;
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= SETTLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1            <= 8'h00;
      s2            <= 8'h00;
      prev          <= 8'h00;
      cnt           <= '0;
      digits        <= 8'h00;
      dblank        <= 2'b11;
      seen          <= 2'b00;
      first         <= 1'b1;
      value_q       <= 8'h00;
      blank_q       <= 2'b11;
      value_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      s1            <= {bus.digit_select, bus.seg_led};
      s2            <= s1;
      prev          <= s2;
      value_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;

      if (changed)           cnt <= '0;
      else if (cnt != C_SAT) cnt <= cnt + CW'(1);

      if (seen == 2'b11) begin
        seen <= 2'b00;
        if (first || ({digits, dblank} != {value_q, blank_q})) begin
          value_q       <= digits;
          blank_q       <= dblank;
          value_valid_q <= 1'b1;
          first         <= 1'b0;
        end
      end

      // Placed after the frame clear so a same-edge commit keeps its seen bit.
      if (commit) begin
        if (!pat_ok) begin
          pattern_err_q <= 1'b1;
        end else if (s2[7]) begin
          digits[7:4] <= nib;
          dblank[1]   <= pat_blank;
          seen[1]     <= 1'b1;
        end else begin
          digits[3:0] <= nib;
          dblank[0]   <= pat_blank;
          seen[0]     <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_led_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_led_decoder: directed stimulus against a behavioural decode model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_seg_led_decoder;

  localparam int STABLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_led_decoder_if bus();

  seg_led_decoder #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int vv_count = 0;
  int pe_count = 0;
  int vv_edge = -1;
  int pe_edge = -1;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: the line stream as sampled two edges late, and the frame builder.
  logic [7:0] md1, md2, mlast, v;
  int         run;
  logic [7:0] mdig;
  logic [1:0] mdbl, mseen;
  bit         mfirst;
  logic [7:0] mval;
  logic [1:0] mblk;
  logic       mvv, mpe;
  bit         mready = 0;

  function automatic bit lookup(input logic [6:0] seg, output logic [3:0] n, output logic b);
    n = 4'h0;
    b = (seg == 7'h00);
    if (b) return 1'b1;
    for (int i = 0; i < 16; i++)
      if (glyph[i] == seg) begin
        n = i[3:0];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] n;
    logic       b;
    edge_cnt++;
    if (!rst) begin
      md1 = 8'h00; md2 = 8'h00; mlast = 8'h00; run = 1;
      mdig = 8'h00; mdbl = 2'b11; mseen = 2'b00; mfirst = 1'b1;
      mval = 8'h00; mblk = 2'b11; mvv = 1'b0; mpe = 1'b0;
      mready = 1'b1;
    end else begin
      v   = md2;
      md2 = md1;
      md1 = {bus.digit_select, bus.seg_led};
      if (v == mlast) begin
        if (run < 1000) run++;
      end else begin
        run   = 1;
        mlast = v;
      end
      mvv = 1'b0;
      mpe = 1'b0;
      if (mseen == 2'b11) begin
        mseen = 2'b00;
        if (mfirst || mdig != mval || mdbl != mblk) begin
          mval = mdig; mblk = mdbl; mvv = 1'b1; mfirst = 1'b0;
        end
      end
      if (run == STABLE_CYCLES) begin
        if (!lookup(v[6:0], n, b)) mpe = 1'b1;
        else if (v[7]) begin mdig[7:4] = n; mdbl[1] = b; mseen[1] = 1'b1; end
        else           begin mdig[3:0] = n; mdbl[0] = b; mseen[0] = 1'b1; end
      end
    end
  end

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mready) begin
      chk8("value", bus.value, mval);
      chk8("blank", {6'd0, bus.blank}, {6'd0, mblk});
      chk8("value_valid", {7'd0, bus.value_valid}, {7'd0, mvv});
      chk8("pattern_err", {7'd0, bus.pattern_err}, {7'd0, mpe});
      if (bus.value_valid === 1'b1) begin vv_count++; vv_edge = edge_cnt; end
      if (bus.pattern_err === 1'b1) begin pe_count++; pe_edge = edge_cnt; end
    end
  end

  task automatic hold(input logic ds, input logic [6:0] seg, input int n);
    bus.digit_select = ds;
    bus.seg_led      = seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int apply_edge;
    int vv0;
    int pe0;
    bus.digit_select = 1'b0;
    bus.seg_led      = 7'h00;

    // Reset held for four edges with random line activity.
    repeat (4) begin
      @(negedge clk);
      bus.digit_select = 1'($urandom_range(0, 1));
      bus.seg_led      = 7'($urandom);
    end
    rst = 1'b1;
    chk8("reset_value", bus.value, 8'h00);
    chk8("reset_blank", {6'd0, bus.blank}, 8'h03);

    // Basic frame: tens 2 then ones 8.
    hold(1'b1, 7'h5B, 10);
    chki("no_pulse_before_frame", vv_count + pe_count, 0);
    apply_edge = edge_cnt;
    hold(1'b0, 7'h7F, 10);
    chki("basic_vv_count", vv_count, 1);
    chki("basic_vv_latency", vv_edge - (apply_edge + 1), 6);
    chk8("basic_value", bus.value, 8'h28);
    chk8("basic_blank", {6'd0, bus.blank}, 8'h00);

    // Identical frames must not re-strobe; a changed ones digit must.
    vv0 = vv_count;
    repeat (3) begin
      hold(1'b1, 7'h5B, 10);
      hold(1'b0, 7'h7F, 10);
    end
    chki("repeat_no_vv", vv_count, vv0);
    hold(1'b1, 7'h5B, 10);
    hold(1'b0, 7'h77, 10);
    chki("change_vv", vv_count, vv0 + 1);
    chk8("change_value", bus.value, 8'h2A);

    // Invalid tens pattern, then a lone ones digit.
    vv0 = vv_count;
    pe0 = pe_count;
    apply_edge = edge_cnt;
    hold(1'b1, 7'h49, 10);
    chki("invalid_pe_count", pe_count, pe0 + 1);
    chki("invalid_pe_latency", pe_edge - (apply_edge + 1), 5);
    hold(1'b0, 7'h77, 10);
    chki("invalid_no_vv", vv_count, vv0);
    chk8("invalid_value", bus.value, 8'h2A);

    // Fast multiplexing is ignored; slow multiplexing frames again.
    pe0 = pe_count;
    for (int i = 0; i < 8; i++) hold((i % 2) == 0, 7'h06, 2);
    chki("fast_no_vv", vv_count, vv0);
    chki("fast_no_pe", pe_count, pe0);
    hold(1'b1, 7'h06, 8);
    hold(1'b0, 7'h06, 8);
    hold(1'b1, 7'h06, 8);
    chki("slow_vv", vv_count, vv0 + 2);
    chk8("slow_value", bus.value, 8'h11);

    // Reset between the two digits of a frame.
    hold(1'b1, 7'h66, 10);
    vv0 = vv_count;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk8("midreset_value", bus.value, 8'h00);
    chk8("midreset_blank", {6'd0, bus.blank}, 8'h03);
    hold(1'b0, 7'h6D, 10);
    chki("midreset_no_vv", vv_count, vv0);
    hold(1'b1, 7'h66, 10);
    chki("midreset_vv", vv_count, vv0 + 1);
    chk8("midreset_frame", bus.value, 8'h45);
    chk8("midreset_frame_blank", {6'd0, bus.blank}, 8'h00);

    // Blank tens digit with a zero ones digit.
    hold(1'b1, 7'h00, 10);
    hold(1'b0, 7'h3F, 10);
    chki("blank_vv", vv_count, vv0 + 2);
    chk8("blank_value", bus.value, 8'h00);
    chk8("blank_flags", {6'd0, bus.blank}, 8'h02);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
